// File: rtl/parent_cap_pkg.sv
// Shared definitions for the PARENT cell capture FIFO: lane positions,
// pointer sizing and occupancy states.
package parent_cap_pkg;

  localparam int LANE_O0 = 0;
  localparam int LANE_O1 = 1;

  localparam int DEFAULT_DEPTH = 4;

  // Pointer width carries one extra MSB so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] count_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/parent_cap_mem.sv
// Register-array storage for the capture FIFO: one synchronous write port,
// one asynchronous read port, no reset on the contents.
module parent_cap_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/parent_capture_fifo.sv
// Capture FIFO behind the two-pin PARENT cell: buffers {O1, O0} words for a
// ready/valid consumer and reports occupancy and sticky overflow.
module parent_capture_fifo
  import parent_cap_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("parent_capture_fifo: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("parent_capture_fifo: WIDTH must be at least 1");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ_count;
  occ_state_t    occ;
  logic          push;
  logic          pop;

  // Occupancy is decoded from the pointer difference alone; no state register.
  assign occ_count = wr_ptr - rd_ptr;

  always_comb begin
    occ = OCC_PARTIAL;
    if (occ_count == '0) begin
      occ = OCC_EMPTY;
    end else if (occ_count == PW'(DEPTH)) begin
      occ = OCC_FULL;
    end
  end

  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == OCC_EMPTY);
  assign count     = occ_count;
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // A dropped push outranks a coincident clear so no overflow goes unseen.
      if (in_valid && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  parent_cap_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_parent_capture_fifo.sv
// Directed bench for parent_capture_fifo with DEPTH=4, WIDTH=2.
module tb_parent_capture_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;

  int n_cmp;
  int n_fail;

  parent_capture_fifo #(.WIDTH(2), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 2'b00;
    out_ready = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", full); end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 2'b01; tick();
    in_data = 2'b10; tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL pre_async_count got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_rst_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_out_valid got %b want 0", out_valid); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_order();
    logic [1:0] exp_q [3];
    exp_q = '{2'b01, 2'b10, 2'b11};
    in_valid = 1'b1; in_data = 2'b01; tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 2'b01) begin n_fail++; $display("FAIL first_word got v=%b d=%b want v=1 d=01", out_valid, out_data); end
    in_data = 2'b10; tick();
    in_data = 2'b11; tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL order_count got %0d want 3", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_data !== exp_q[i]) begin n_fail++; $display("FAIL order_pop%0d got %b want %b", i, out_data, exp_q[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL order_empty got %b want 1", empty); end
  endtask

  task automatic test_full_overflow();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(i); tick();
    end
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got full=%b rdy=%b want 1/0", full, in_ready); end
    in_data = 2'b10; tick();
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data !== 2'(i)) begin n_fail++; $display("FAIL ovf_pop%0d got %b want %b", i, out_data, 2'(i)); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got empty=%b want 1", empty); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_q [6];
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    in_valid = 1'b1;
    in_data = 2'd0; tick();
    in_data = 2'd1; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 2'(i + 2);
      n_cmp++; if (out_data !== exp_q[i] || count !== 3'd2) begin n_fail++; $display("FAIL b2b_%0d got d=%b cnt=%0d want d=%b cnt=2", i, out_data, count, exp_q[i]); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 2'd2) begin n_fail++; $display("FAIL b2b_tail0 got %b want 10", out_data); end
    tick();
    n_cmp++; if (out_data !== 2'd3) begin n_fail++; $display("FAIL b2b_tail1 got %b want 11", out_data); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] fill_q [4];
    logic [1:0] exp_q [3];
    fill_q = '{2'b01, 2'b01, 2'b10, 2'b10};
    exp_q  = '{2'b01, 2'b10, 2'b10};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill_q[i]; tick();
    end
    in_data = 2'b11; out_ready = 1'b1; tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fpp_count got %0d want 3", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_data !== exp_q[i]) begin n_fail++; $display("FAIL fpp_pop%0d got %b want %b", i, out_data, exp_q[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %b want 1", empty); end
  endtask

  task automatic test_clr_overflow();
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_plain got %b want 0", overflow); end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(3 - i); tick();
    end
    in_data = 2'b00; clr_overflow = 1'b1; tick();
    in_valid = 1'b0; clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set got %b want 1", overflow); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL clr_count got %0d want 4", count); end
    n_cmp++; if (out_data !== 2'b11) begin n_fail++; $display("FAIL clr_head got %b want 11", out_data); end
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_order();
    test_full_overflow();
    test_back_to_back();
    test_full_push_pop();
    test_clr_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
